// File: rtl/calc_pkg.sv
// Shared ALU opcodes, FSM states and width for gencon and seq_alu.
package calc_pkg;
  localparam int CALC_WIDTH = 16;

  typedef enum logic [1:0] {
    OP_ADD,
    OP_SUB,
    OP_MUL,
    OP_DIV
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } alu_state_t;
endpackage

// File: rtl/seq_muldiv_iter.sv
// Unsigned WIDTH-step shift-add multiplier / restoring divider.
// One shared accumulator: {hi, lo} is {partial, multiplier} or {rem, quotient}.
module seq_muldiv_iter
  import calc_pkg::*;
#(
  parameter int WIDTH = CALC_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               mode,
  input  logic [WIDTH-1:0]   mag_a,
  input  logic [WIDTH-1:0]   mag_b,
  output logic [2*WIDTH-1:0] prod_quo,
  output logic [WIDTH-1:0]   rem,
  output logic               done
);
  localparam int CW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               mode_q, mode_d;
  logic               act_q, act_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic [WIDTH:0] hi_sum;
  logic [WIDTH:0] top;
  logic [WIDTH:0] top_sub;
  logic           last;

  assign last = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    acc_d  = acc_q;
    b_d    = b_q;
    mode_d = mode_q;
    act_d  = act_q;
    cnt_d  = cnt_q;
    hi_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
           + (acc_q[0] ? {1'b0, b_q} : '0);
    top     = acc_q[2*WIDTH-1:WIDTH-1];
    top_sub = top - {1'b0, b_q};
    if (load) begin
      acc_d  = {{WIDTH{1'b0}}, mag_a};
      b_d    = mag_b;
      mode_d = mode;
      act_d  = 1'b1;
      cnt_d  = '0;
    end else if (act_q) begin
      if (mode_q) begin
        // no borrow means the shifted remainder covers the divisor
        if (!top_sub[WIDTH])
          acc_d = {top_sub[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        else
          acc_d = {top[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end else begin
        acc_d = {hi_sum, acc_q[WIDTH-1:1]};
      end
      if (last) begin
        act_d = 1'b0;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q  <= '0;
      b_q    <= '0;
      mode_q <= 1'b0;
      act_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      acc_q  <= acc_d;
      b_q    <= b_d;
      mode_q <= mode_d;
      act_q  <= act_d;
      cnt_q  <= cnt_d;
    end
  end

  assign done     = act_q && last;
  assign prod_quo = mode_q ? {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]} : acc_q;
  assign rem      = acc_q[2*WIDTH-1:WIDTH];
endmodule

// File: rtl/seq_alu.sv
// Multi-cycle signed ADD/SUB/MUL/DIV unit downstream of gencon.
// Optional ALU_REM_EN adds the signed DIV remainder output ALU_rem.
module seq_alu
  import calc_pkg::*;
#(
  parameter int WIDTH = CALC_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_calc,
  input  logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] ALU_in1,
  input  logic [WIDTH-1:0] ALU_in2,
  output logic [WIDTH-1:0] ALU_out,
  output logic             ALU_finish,
  output logic             busy,
  output logic             overflow,
  output logic             div_zero
`ifdef ALU_REM_EN
  ,
  output logic [WIDTH-1:0] ALU_rem
`endif
);
  alu_state_t       state_q, state_d;
  alu_op_t          op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             load_q, load_d;
  logic             busy_q, busy_d;
  logic             fin_q, fin_d;
  logic             ovf_q, ovf_d;
  logic             dz_q, dz_d;

  logic [WIDTH:0]     a_mag_w, b_mag_w;
  logic [2*WIDTH-1:0] it_prod;
  logic [WIDTH-1:0]   it_rem;
  logic               it_done;
  logic               b_zero, neg, short_op;

  logic [WIDTH:0]     sum_w, dif_w, quo_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   res_out, res_rem;
  logic               res_ovf, res_dz;
  logic               unused_bits;

  assign b_zero   = (b_q == '0);
  assign neg      = a_q[WIDTH-1] ^ b_q[WIDTH-1];
  assign short_op = !op_q[1] || (op_q == OP_DIV && b_zero);

  // -2^(WIDTH-1) only has a magnitude in WIDTH+1 bits
  assign a_mag_w = a_q[WIDTH-1] ? -{a_q[WIDTH-1], a_q} : {a_q[WIDTH-1], a_q};
  assign b_mag_w = b_q[WIDTH-1] ? -{b_q[WIDTH-1], b_q} : {b_q[WIDTH-1], b_q};

  seq_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk      (clk),
    .reset    (reset),
    .load     (load_q),
    .mode     (op_q == OP_DIV),
    .mag_a    (a_mag_w[WIDTH-1:0]),
    .mag_b    (b_mag_w[WIDTH-1:0]),
    .prod_quo (it_prod),
    .rem      (it_rem),
    .done     (it_done)
  );

  always_comb begin
    res_out = '0;
    res_rem = '0;
    res_ovf = 1'b0;
    res_dz  = 1'b0;
    sum_w   = {a_q[WIDTH-1], a_q} + {b_q[WIDTH-1], b_q};
    dif_w   = {a_q[WIDTH-1], a_q} - {b_q[WIDTH-1], b_q};
    prod_s  = neg ? -it_prod : it_prod;
    quo_s   = neg ? -{1'b0, it_prod[WIDTH-1:0]}
                  : {1'b0, it_prod[WIDTH-1:0]};
    unique case (op_q)
      OP_ADD: begin
        res_out = sum_w[WIDTH-1:0];
        res_ovf = sum_w[WIDTH] ^ sum_w[WIDTH-1];
      end
      OP_SUB: begin
        res_out = dif_w[WIDTH-1:0];
        res_ovf = dif_w[WIDTH] ^ dif_w[WIDTH-1];
      end
      OP_MUL: begin
        res_out = prod_s[WIDTH-1:0];
        res_ovf = !((&prod_s[2*WIDTH-1:WIDTH-1])
                 || ~|prod_s[2*WIDTH-1:WIDTH-1]);
      end
      OP_DIV: begin
        if (b_zero) begin
          res_dz = 1'b1;
        end else begin
          res_out = quo_s[WIDTH-1:0];
          res_ovf = quo_s[WIDTH] ^ quo_s[WIDTH-1];
          res_rem = a_q[WIDTH-1] ? -it_rem : it_rem;
        end
      end
      default: res_out = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    out_d   = out_q;
    load_d  = 1'b0;
    busy_d  = busy_q;
    fin_d   = 1'b0;
    ovf_d   = ovf_q;
    dz_d    = dz_q;
    unique case (state_q)
      IDLE: begin
        if (start_calc) begin
          op_d    = alu_op_t'(alu_op);
          a_d     = ALU_in1;
          b_d     = ALU_in2;
          ovf_d   = 1'b0;
          dz_d    = 1'b0;
          busy_d  = 1'b1;
          load_d  = alu_op[1] && !(alu_op == OP_DIV && ALU_in2 == '0);
          state_d = CALC;
        end
      end
      CALC: begin
        if (short_op || it_done)
          state_d = DONE;
      end
      DONE: begin
        out_d   = res_out;
        ovf_d   = res_ovf;
        dz_d    = res_dz;
        fin_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
      load_q  <= 1'b0;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      out_q   <= out_d;
      load_q  <= load_d;
      busy_q  <= busy_d;
      fin_q   <= fin_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
    end
  end

  assign ALU_out    = out_q;
  assign ALU_finish = fin_q;
  assign busy       = busy_q;
  assign overflow   = ovf_q;
  assign div_zero   = dz_q;

`ifdef ALU_REM_EN
  logic [WIDTH-1:0] rem_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      rem_q <= '0;
    else if (state_q == DONE)
      rem_q <= res_rem;
  end

  assign ALU_rem     = rem_q;
  assign unused_bits = ^{a_mag_w[WIDTH], b_mag_w[WIDTH]};
`else
  assign unused_bits = ^{a_mag_w[WIDTH], b_mag_w[WIDTH], res_rem};
`endif
endmodule
